// File: rtl/regfile_mp.sv
// Multi-ported register file: two write ports, NUM_RD combinational read ports, and a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 2,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [1:0]                   i_we,
    input  logic [2*AW-1:0]              i_waddr,
    input  logic [2*DATA_WIDTH-1:0]      i_wdata,
    input  logic [NUM_RD*AW-1:0]         i_raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rdata,
    output logic [NUM_RD-1:0]            o_rbusy,
    input  logic                         i_alloc_valid,
    input  logic [AW-1:0]                i_alloc_addr,
    output logic [NUM_REGS-1:0]          o_busy
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [AW-1:0]         waddr [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic                  wr_en [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            waddr[k] = i_waddr[k*AW +: AW];
            wdata[k] = i_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            wr_en[k] = i_we[k] && (waddr[k] != '0);
        end
    end

    // Clears from writes are applied before the alloc so a same-cycle re-allocation wins.
    always_comb begin
        busy_next = busy;
        for (int k = 0; k < 2; k++) begin
            if (wr_en[k]) begin
                busy_next[waddr[k]] = 1'b0;
            end
        end
        if (i_alloc_valid && (i_alloc_addr != '0)) begin
            busy_next[i_alloc_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Port 1 is applied last so it overrides port 0 on an address collision.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wr_en[k]) begin
                    regs[waddr[k]] <= wdata[k];
                end
            end
            busy <= busy_next;
        end
    end

    always_comb begin
        logic [AW-1:0]         ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;
        o_rdata = '0;
        o_rbusy = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            ra = i_raddr[j*AW +: AW];
            rd = (ra == '0) ? '0 : regs[ra];
            rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed in reset so outputs read zero immediately.
            for (int k = 0; k < 2; k++) begin
                if (i_rst_n && wr_en[k] && (waddr[k] == ra)) begin
                    rd = wdata[k];
                    rb = i_alloc_valid && (i_alloc_addr == ra);
                end
            end
`endif
            o_rdata[j*DATA_WIDTH +: DATA_WIDTH] = rd;
            o_rbusy[j] = rb;
        end
    end

    assign o_busy = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic against an array-based model.
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int AW  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        we;
    logic [AW-1:0]     wa [2];
    logic [DW-1:0]     wd [2];
    logic [AW-1:0]     ra [2];
    logic              av;
    logic [AW-1:0]     aa;
    logic [2*AW-1:0]   waddr;
    logic [2*DW-1:0]   wdata;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]    rbusy;
    logic [NR-1:0]     busy;

    logic [DW-1:0] mem [NR];
    bit            mbusy [NR];
    int            testsRun = 0;
    int            failCount = 0;

    assign waddr = {wa[1], wa[0]};
    assign wdata = {wd[1], wd[0]};
    assign raddr = {ra[1], ra[0]};

    regfile_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr(raddr), .o_rdata(rdata), .o_rbusy(rbusy),
        .i_alloc_valid(av), .i_alloc_addr(aa), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkVal(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        testsRun++;
        assert (got === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit sameCycleWrite(logic [AW-1:0] a, output logic [DW-1:0] d);
        bit hit = 0;
        d = '0;
`ifdef REGFILE_BYPASS_EN
        if (rst_n && a != 0) begin
            if (we[0] && wa[0] == a) begin hit = 1; d = wd[0]; end
            if (we[1] && wa[1] == a) begin hit = 1; d = wd[1]; end
        end
`endif
        return hit;
    endfunction

    function automatic logic [DW-1:0] expRead(logic [AW-1:0] a);
        logic [DW-1:0] d;
        if (!rst_n || a == 0) return '0;
        if (sameCycleWrite(a, d)) return d;
        return mem[a];
    endfunction

    function automatic logic expRbusy(logic [AW-1:0] a);
        logic [DW-1:0] d;
        if (!rst_n || a == 0) return 1'b0;
        if (sameCycleWrite(a, d)) return av && (aa == a);
        return mbusy[a];
    endfunction

    task automatic modelReset();
        for (int r = 0; r < NR; r++) begin
            mem[r] = '0;
            mbusy[r] = 0;
        end
    endtask

    // Model edge: stores first (port 1 last wins), then write clears, then alloc sets.
    task automatic modelClock();
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) if (we[k] && wa[k] != 0) mem[wa[k]] = wd[k];
        for (int k = 0; k < 2; k++) if (we[k] && wa[k] != 0) mbusy[wa[k]] = 0;
        if (av && aa != 0) mbusy[aa] = 1;
    endtask

    task automatic checkOutput(string tag);
        logic [DW-1:0] expBusy;
        expBusy = '0;
        for (int r = 0; r < NR; r++) expBusy[r] = mbusy[r];
        for (int j = 0; j < NRD; j++) begin
            checkVal($sformatf("%s rdata%0d r%0d", tag, j, ra[j]), rdata[j*DW +: DW], expRead(ra[j]));
            checkVal($sformatf("%s rbusy%0d r%0d", tag, j, ra[j]), {31'b0, rbusy[j]}, {31'b0, expRbusy(ra[j])});
        end
        checkVal($sformatf("%s o_busy", tag), busy, expBusy);
    endtask

    task automatic applyStimulus(string tag, logic [1:0] w, logic [AW-1:0] a0, logic [DW-1:0] d0,
                                 logic [AW-1:0] a1, logic [DW-1:0] d1, logic [AW-1:0] r0,
                                 logic [AW-1:0] r1, logic v, logic [AW-1:0] va);
        @(negedge clk);
        we = w; wa[0] = a0; wd[0] = d0; wa[1] = a1; wd[1] = d1;
        ra[0] = r0; ra[1] = r1; av = v; aa = va;
        #1 checkOutput(tag);
        @(posedge clk);
        modelClock();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        we = '0; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
        ra[0] = '0; ra[1] = '0; av = 1'b0; aa = '0;
        modelReset();
        #12;
        checkOutput("in_reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NR / 2; i++)
            applyStimulus("post_reset", 2'b00, 0, 0, 0, 0, AW'(2*i), AW'(2*i+1), 0, 0);

        applyStimulus("dual_write", 2'b11, 5, 32'hDEADBEEF, 6, 32'h12345678, 5, 6, 0, 0);
        applyStimulus("dual_read", 2'b00, 0, 0, 0, 0, 5, 6, 0, 0);
        checkVal("r5_value", rdata[0 +: DW], 32'hDEADBEEF);
        checkVal("r6_value", rdata[DW +: DW], 32'h12345678);

        applyStimulus("collide", 2'b11, 7, 32'h1111, 7, 32'h2222, 7, 7, 0, 0);
        applyStimulus("r0_write", 2'b01, 0, 32'hFFFF, 0, 0, 7, 0, 0, 0);
        checkVal("r7_port1_wins", rdata[0 +: DW], 32'h2222);
        applyStimulus("r0_read", 2'b00, 0, 0, 0, 0, 0, 7, 1, 0);
        checkVal("r0_reads_zero", rdata[0 +: DW], 32'h0);

        applyStimulus("alloc9", 2'b00, 0, 0, 0, 0, 9, 9, 1, 9);
        applyStimulus("wr_alloc9", 2'b01, 9, 32'hA5, 0, 0, 9, 0, 1, 9);
        checkVal("busy9_set", {31'b0, busy[9]}, 32'd1);
        applyStimulus("wr9", 2'b10, 0, 0, 9, 32'h5A, 9, 1, 0, 0);
        checkVal("busy9_kept", {31'b0, busy[9]}, 32'd1);
        applyStimulus("read9", 2'b00, 0, 0, 0, 0, 9, 0, 0, 0);
        checkVal("busy9_clear", {31'b0, busy[9]}, 32'd0);
        checkVal("r9_value", rdata[0 +: DW], 32'h5A);

        applyStimulus("alloc3", 2'b00, 0, 0, 0, 0, 3, 0, 1, 3);
        applyStimulus("wr_rd3", 2'b01, 3, 32'hCAFE, 0, 0, 3, 3, 0, 0);
`ifdef REGFILE_BYPASS_EN
        checkVal("bypass_r3", rdata[0 +: DW], 32'hCAFE);
`else
        checkVal("nobypass_r3", rdata[0 +: DW], 32'h0);
        checkVal("nobypass_rbusy3", {31'b0, rbusy[0]}, 32'd1);
`endif
        applyStimulus("rd3", 2'b00, 0, 0, 0, 0, 3, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] lim;
            lim = (i % 3 == 0) ? AW'(7) : AW'(NR - 1);
            applyStimulus("random", 2'($urandom),
                          AW'($urandom_range(0, lim)), $urandom,
                          AW'($urandom_range(0, lim)), $urandom,
                          AW'($urandom_range(0, lim)), AW'($urandom_range(0, lim)),
                          1'($urandom), AW'($urandom_range(0, lim)));
        end

        for (int r = 1; r <= 4; r++)
            applyStimulus("pre_rst", 2'b01, AW'(r), DW'(32'h100 + r), 0, 0, AW'(r), 0, 1, AW'(r + 10));
        @(negedge clk);
        we = 2'b01; wa[0] = 10; wd[0] = 32'h77; ra[0] = 1; ra[1] = 10; av = 1'b1; aa = 10;
        #2 rst_n = 1'b0;
        modelReset();
        #1 checkOutput("async_rst");
        checkVal("async_rst_busy", busy, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        we = '0; av = 1'b0;
        #1 checkOutput("rst_release");
        checkVal("inflight_dropped", rdata[DW +: DW], 32'h0);
        applyStimulus("first_write", 2'b10, 0, 0, 11, 32'hBEEF, 11, 10, 0, 0);
        applyStimulus("first_read", 2'b00, 0, 0, 0, 0, 11, 10, 0, 0);
        checkVal("first_write_value", rdata[0 +: DW], 32'hBEEF);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count (power of two, >=2); localparam AW = $clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2, read port count (>=1).
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port i_we  input  2  write enable, bit k = write port k.
REQ-007 SHALL have port i_waddr  input  2*AW  write addresses, port k at [k*AW +: AW].
REQ-008 SHALL have port i_wdata  input  2*DATA_WIDTH  write data, port k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port i_raddr  input  NUM_RD*AW  read addresses, port j at [j*AW +: AW].
REQ-010 SHALL have port o_rdata  output  NUM_RD*DATA_WIDTH  read data, port j at [j*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port o_rbusy  output  NUM_RD  per-read-port pending-write flag.
REQ-012 SHALL have port i_alloc_valid  input  1  mark a destination register pending.
REQ-013 SHALL have port i_alloc_addr  input  AW  register to mark pending.
REQ-014 SHALL have port o_busy  output  NUM_REGS  registered scoreboard vector, bit r = register r pending.

Function
REQ-015 Register 0 SHALL read as 0 on every port, SHALL ignore writes and SHALL never be busy (o_busy[0] = 0, alloc to 0 ignored).
REQ-016 Write port k with i_we[k]=1 and i_waddr k != 0 SHALL update that register at the rising edge; both ports SHALL write in the same cycle when addresses differ.
REQ-017 Both write ports enabled to the same non-zero address SHALL store port 1 data; port 0 data discarded.
REQ-018 Reads SHALL be combinational: o_rdata port j = register[i_raddr j] with zero-cycle latency and no enable.
REQ-019 i_alloc_valid=1 with non-zero i_alloc_addr SHALL set o_busy[i_alloc_addr] at the rising edge.
REQ-020 A write (either port) to register r SHALL clear o_busy[r] at the rising edge.
REQ-021 Alloc and write to the same register in the same cycle SHALL leave the bit set (the new allocation wins); the data write still occurs.
REQ-022 Alloc of an already-busy register SHALL keep it busy (no counting; one write clears it).
REQ-023 o_rbusy[j] SHALL equal o_busy[i_raddr j], subject to REQ-027.

Reset
REQ-024 i_rst_n low SHALL immediately, independent of i_clk, clear all registers to 0 and o_busy to 0; o_rdata therefore reads 0 and o_rbusy reads 0.
REQ-025 Reset asserted mid-operation SHALL discard any write or alloc in that cycle; the first write after deassertion SHALL occur at the first rising edge with i_rst_n high.
REQ-026 No initial blocks SHALL be relied on for state; reset alone defines it.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN defined: read port j whose non-zero address matches an enabled write address in the same cycle SHALL return that write data (port 1 priority per REQ-017) and SHALL report o_rbusy[j]=0 unless a same-cycle alloc targets it; o_busy unchanged (still registered).
REQ-028 REGFILE_BYPASS_EN undefined: read ports SHALL return the stored (pre-edge) value and o_rbusy SHALL be the pure registered o_busy lookup; no write-to-read combinational path SHALL exist.

Verification
REQ-029 Reset release, read all addresses on both ports -> o_rdata = 0, o_busy = 0.
REQ-030 Port0 writes r5=0xDEADBEEF, port1 writes r6=0x12345678 same cycle; next cycle read r5,r6 -> 0xDEADBEEF, 0x12345678.
REQ-031 Both ports write r7 (0x1111 on port0, 0x2222 on port1); next cycle read r7 -> 0x2222; write r0=0xFFFF then read r0 -> 0.
REQ-032 Alloc r9; next cycle o_busy[9]=1, o_rbusy=1 when reading r9; write r9=0xA5 while allocing r9 again -> busy stays 1; following write r9 -> busy 0.
REQ-033 Write r3=0xCAFE and read r3 same cycle -> 0xCAFE with REGFILE_BYPASS_EN, old value (0) without; o_rbusy for r3 per REQ-027/028.
REQ-034 After writes to r1..r4 and allocs, pulse i_rst_n low between clock edges -> all outputs 0 immediately, the next in-flight write discarded.
